// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg
// Shared definitions for the data-memory port arbiter.
//   - lockOwner_e : encoding of which requester currently holds a short-term lock
//   - MEM_WORDS   : depth of the data memory behind the port
//   - WORD_LSB    : lowest byte-address bit that forms the word address
//   - BYTE_OFS_W  : number of byte-offset bits dropped when forming the word address
//   - isMisaligned: flags a byte address that is not word aligned
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'b00,
    LOCK_R0   = 2'b01,
    LOCK_R1   = 2'b10
  } lockOwner_e;

  localparam int MEM_WORDS  = 1024;
  localparam int WORD_LSB   = 2;
  localparam int BYTE_OFS_W = 2;

  // Any set byte-offset bit means the access does not hit a whole word.
  function automatic logic isMisaligned(input logic [BYTE_OFS_W-1:0] byteOfs);
    return byteOfs != '0;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin picker with short-term locking and a starvation limit.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req[1:0]   in   request per requester
//   lock[1:0]  in   request to keep ownership for the next cycle
//   gnt[1:0]   out  one-hot (or zero) grant, combinational
// Parameter:
//   MAX_BURST  maximum consecutive grants to one requester while the other waits (1..15)
module rr_arb2
  import dmem_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  lockOwner_e lockState;
  lockOwner_e lockNext;
  logic       lastOwner;
  logic       lastOwnerNext;
  logic [3:0] burstCnt;
  logic [3:0] burstNext;
  logic       winner;
  logic       otherReq;
  logic       forceRelease;

  assign winner   = gnt[1];
  assign otherReq = winner ? req[0] : req[1];

  // Lock state register. Reset drops any lock so a pending owner never survives reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lockState <= LOCK_NONE;
    end else begin
      lockState <= lockNext;
    end
  end

  // Round-robin history and burst length. lastOwner resets to 1 so requester 0
  // wins the very first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastOwner <= 1'b1;
      burstCnt  <= '0;
    end else begin
      lastOwner <= lastOwnerNext;
      burstCnt  <= burstNext;
    end
  end

  // Next-state logic. The burst counter only grows while the other side is
  // waiting; once it reaches the limit the lock is torn down so round-robin hands
  // the next contention to the waiting requester. A forced release also
  // blocks re-locking in the same cycle so the limit cannot be overshot.
  always_comb begin
    lockNext      = lockState;
    lastOwnerNext = lastOwner;
    burstNext     = burstCnt;
    forceRelease  = 1'b0;

    if (|gnt) begin
      lastOwnerNext = winner;
      if (!otherReq) begin
        burstNext = '0;
      end else if (winner != lastOwner) begin
        burstNext = 4'd1;
      end else if (burstCnt < BURST_MAX) begin
        burstNext = burstCnt + 4'd1;
      end
      forceRelease = otherReq && (burstNext == BURST_MAX);
    end

    unique case (lockState)
      LOCK_NONE: begin
        if ((|gnt) && lock[winner] && !forceRelease) begin
          lockNext = winner ? LOCK_R1 : LOCK_R0;
        end
      end
      LOCK_R0: begin
        if (!lock[0] || !req[0] || forceRelease) begin
          lockNext = LOCK_NONE;
        end
      end
      LOCK_R1: begin
        if (!lock[1] || !req[1] || forceRelease) begin
          lockNext = LOCK_NONE;
        end
      end
      default: lockNext = LOCK_NONE;
    endcase
  end

  // Grant decode: a lone requester always wins; under contention the lock
  // holder wins, otherwise whoever did not win last time.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b01) begin
      gnt = 2'b01;
    end else if (req == 2'b10) begin
      gnt = 2'b10;
    end else if (req == 2'b11) begin
      if (lockState == LOCK_R0) begin
        gnt = 2'b01;
      end else if (lockState == LOCK_R1) begin
        gnt = 2'b10;
      end else begin
        gnt = lastOwner ? 2'b01 : 2'b10;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single synchronous data-memory port between the pipeline MEM stage
// (requester 0) and the loader/DMA engine (requester 1).
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   reqN, lockN, weN           request, lock request, write enable per requester
//   addrN, wdataN              byte address and write data per requester
//   gntN, errN                 combinational grant and misalignment flag
//   rvalidN, rdata             read data valid (one cycle after a read grant), shared data
//   mem_we, mem_addr, mem_din  memory drive
//   mem_dout                   memory read data, valid one cycle after the address
//   gcnt0, gcnt1               per-requester grant counters
// Optional feature: define DMEM_ARB_STATS_EN to enable the 16-bit wrapping grant
// counters; without it gcnt0/gcnt1 are tied to zero.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              err0,
  output logic              err1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       gcnt0,
  output logic [15:0]       gcnt1
);

  logic [1:0] gnt;
  logic       rdPend0;
  logic       rdPend1;
  logic       unusedAddrBits;

  rr_arb2 #(
    .MAX_BURST(MAX_BURST)
  ) uArb (
    .clk  (clk),
    .reset(reset),
    .req  ({req1, req0}),
    .lock ({lock1, lock0}),
    .gnt  (gnt)
  );

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  assign err0 = gnt0 & isMisaligned(addr0[BYTE_OFS_W-1:0]);
  assign err1 = gnt1 & isMisaligned(addr1[BYTE_OFS_W-1:0]);

  // Upper byte-address bits beyond the memory depth are ignored.
  assign unusedAddrBits = ^{addr0[31:ADDR_W+WORD_LSB], addr1[31:ADDR_W+WORD_LSB]};

  // Memory drive. When idle the port still shows requester 0's address and data
  // so the MEM stage sees the same behaviour as a direct connection; writes are
  // suppressed for misaligned accesses, but reads go through on the truncated word.
  always_comb begin
    mem_addr = addr0[ADDR_W+WORD_LSB-1:WORD_LSB];
    mem_din  = wdata0;
    mem_we   = 1'b0;
    if (gnt1) begin
      mem_addr = addr1[ADDR_W+WORD_LSB-1:WORD_LSB];
      mem_din  = wdata1;
      mem_we   = we1 & ~err1;
    end else if (gnt0) begin
      mem_we = we0 & ~err0;
    end
  end

  // Read-pending flags: memory returns data one cycle after the address, so the
  // valid strobe is just the read grant delayed by one clock. Reset drops it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPend0 <= 1'b0;
      rdPend1 <= 1'b0;
    end else begin
      rdPend0 <= gnt0 & ~we0;
      rdPend1 <= gnt1 & ~we1;
    end
  end

  assign rvalid0 = rdPend0;
  assign rvalid1 = rdPend1;
  assign rdata   = mem_dout;

`ifdef DMEM_ARB_STATS_EN
  // Grant statistics, free-running and wrapping at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else begin
      if (gnt0) begin
        gcnt0 <= gcnt0 + 16'd1;
      end
      if (gnt1) begin
        gcnt1 <= gcnt1 + 16'd1;
      end
    end
  end
`else
  assign gcnt0 = '0;
  assign gcnt1 = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Directed test of dmem_port_arbiter with a behavioural memory, a reference model
// checked every cycle, and literal expectations for the key scenarios.
// Honours DMEM_ARB_STATS_EN to check the grant counters.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int WORDS     = 1024;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic              lock0 = 1'b0, lock1 = 1'b0;
  logic              we0 = 1'b0, we1 = 1'b0;
  logic [31:0]       addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, err0, err1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic [15:0]       gcnt0, gcnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .gcnt0(gcnt0), .gcnt1(gcnt1)
  );

  // Synchronous memory, write-first, registered read.
  logic [DATA_W-1:0] memArr [0:WORDS-1];
  always @(posedge clk) begin
    if (mem_we) memArr[mem_addr] <= mem_din;
    mem_dout <= mem_we ? mem_din : memArr[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Reference model state, kept as plain integers.
  int          lastWinner = 1;
  int          lockedTo = -1;
  int          runLen = 0;
  bit          pendRd [2] = '{1'b0, 1'b0};
  bit          pendKnown = 1'b0;
  logic [31:0] pendData = '0;
  int          gcntModel [2] = '{0, 0};
  logic [31:0] shadow [int];

  task automatic modelCycle();
    int          winner;
    int          other;
    int          key;
    int          sel;
    bit          forced;
    bit          r [2];
    bit          l [2];
    bit          w [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    r = '{req0, req1};
    l = '{lock0, lock1};
    w = '{we0, we1};
    a = '{addr0, addr1};
    d = '{wdata0, wdata1};
    if (reset) begin
      lastWinner = 1;
      lockedTo   = -1;
      runLen     = 0;
      pendRd     = '{1'b0, 1'b0};
      gcntModel  = '{0, 0};
    end
    winner = -1;
    if (r[0] && r[1]) winner = (lockedTo >= 0) ? lockedTo : 1 - lastWinner;
    else if (r[0]) winner = 0;
    else if (r[1]) winner = 1;
    sel = (winner == 1) ? 1 : 0;

    checkOutput("gnt0", 32'(gnt0), 32'(winner == 0));
    checkOutput("gnt1", 32'(gnt1), 32'(winner == 1));
    checkOutput("err0", 32'(err0), 32'(winner == 0 && (a[0] % 4) != 0));
    checkOutput("err1", 32'(err1), 32'(winner == 1 && (a[1] % 4) != 0));
    checkOutput("mem_we", 32'(mem_we), 32'(winner >= 0 && w[sel] && (a[sel] % 4) == 0));
    checkOutput("mem_addr", 32'(mem_addr), (a[sel] / 4) % WORDS);
    checkOutput("mem_din", mem_din, d[sel]);
    checkOutput("rvalid0", 32'(rvalid0), 32'(pendRd[0]));
    checkOutput("rvalid1", 32'(rvalid1), 32'(pendRd[1]));
    if ((pendRd[0] || pendRd[1]) && pendKnown) checkOutput("rdata", rdata, pendData);
    checkOutput("gcnt0", 32'(gcnt0), gcntModel[0]);
    checkOutput("gcnt1", 32'(gcnt1), gcntModel[1]);
    if (reset) return;

    pendRd = '{1'b0, 1'b0};
    forced = 1'b0;
    if (winner >= 0) begin
      other = 1 - winner;
      key = int'((a[winner] / 4) % WORDS);
      if (w[winner]) begin
        if ((a[winner] % 4) == 0) shadow[key] = d[winner];
      end else begin
        pendRd[winner] = 1'b1;
        pendKnown = shadow.exists(key);
        if (pendKnown) pendData = shadow[key];
      end
`ifdef DMEM_ARB_STATS_EN
      gcntModel[winner] = (gcntModel[winner] + 1) % 65536;
`endif
      if (!r[other]) runLen = 0;
      else if (winner != lastWinner) runLen = 1;
      else if (runLen < MAX_BURST) runLen = runLen + 1;
      forced = r[other] && runLen == MAX_BURST;
      lastWinner = winner;
    end
    if (lockedTo < 0) begin
      if (winner >= 0 && l[winner] && !forced) lockedTo = winner;
    end else if (!r[lockedTo] || !l[lockedTo] || forced) begin
      lockedTo = -1;
    end
  endtask

  initial begin : compareProc
    forever begin
      @(negedge clk);
      modelCycle();
    end
  end

  task automatic applyStimulus(
    input bit r0, input bit l0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
    input bit r1, input bit l1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    req0 = r0; lock0 = l0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; lock1 = l1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic doReset();
    applyIdle();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  bit expG1 [7];

  initial begin : stimulusProc
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    checkOutput("rst_gnt0", 32'(gnt0), 32'h0);
    checkOutput("rst_rvalid0", 32'(rvalid0), 32'h0);
    checkOutput("rst_rvalid1", 32'(rvalid1), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_gcnt0", 32'(gcnt0), 32'h0);

    // Solo traffic from requester 0: write then read back.
    applyStimulus(1, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0);
    #2 checkOutput("solo_wr_gnt0", 32'(gnt0), 32'h1);
    checkOutput("solo_wr_we", 32'(mem_we), 32'h1);
    checkOutput("solo_wr_gnt1", 32'(gnt1), 32'h0);
    applyStimulus(1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    #2 checkOutput("solo_rd_gnt0", 32'(gnt0), 32'h1);
    checkOutput("solo_rd_gnt1", 32'(gnt1), 32'h0);
    applyIdle();
    #2 checkOutput("solo_rvalid0", 32'(rvalid0), 32'h1);
    checkOutput("solo_rdata", rdata, 32'hDEADBEEF);

    // Requester 1 preloads another word.
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h20, 32'hAAAA5555);
    #2 checkOutput("pre_gnt1", 32'(gnt1), 32'h1);

    // Contention after reset: R0, R1, R0, R1 with rvalid following each grant.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 32'h10, 32'h0, 1, 0, 0, 32'h20, 32'h0);
      #2 checkOutput("rr_gnt0", 32'(gnt0), 32'((i % 2) == 0));
      checkOutput("rr_gnt1", 32'(gnt1), 32'((i % 2) == 1));
      if (i > 0) begin
        checkOutput("rr_rvalid0", 32'(rvalid0), 32'((i % 2) == 1));
        checkOutput("rr_rdata", rdata, ((i % 2) == 1) ? 32'hDEADBEEF : 32'hAAAA5555);
      end
    end
    applyIdle();
    #2 checkOutput("rr_last_rvalid1", 32'(rvalid1), 32'h1);
    checkOutput("rr_last_rdata", rdata, 32'hAAAA5555);

    // Lock and starvation limit: R1 locks alone, R0 joins; R1 keeps 4 contended
    // grants, R0 gets one, then R1 resumes.
    doReset();
    expG1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(i > 0, 0, 0, 32'h10, 32'h0, 1, 1, 0, 32'h20, 32'h0);
      #2 checkOutput("lock_gnt1", 32'(gnt1), 32'(expG1[i]));
      checkOutput("lock_gnt0", 32'(gnt0), 32'(!expG1[i]));
    end
    applyIdle();

    // Misaligned write is granted but suppressed; reads use the truncated word.
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h22, 32'h1);
    #2 checkOutput("mis_gnt1", 32'(gnt1), 32'h1);
    checkOutput("mis_err1", 32'(err1), 32'h1);
    checkOutput("mis_mem_we", 32'(mem_we), 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h20, 32'h0);
    #2 checkOutput("mis_rd_err1", 32'(err1), 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h22, 32'h0);
    #2 checkOutput("mis_rdata_old", rdata, 32'hAAAA5555);
    checkOutput("mis_rd22_err1", 32'(err1), 32'h1);
    applyIdle();
    #2 checkOutput("mis_rd22_rvalid1", 32'(rvalid1), 32'h1);
    checkOutput("mis_rd22_rdata", rdata, 32'hAAAA5555);

    // Reset in the middle of a locked read: no rvalid, lock gone, R0 wins next.
    applyStimulus(1, 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    #2 checkOutput("rstmid_gnt0", 32'(gnt0), 32'h1);
    req0 = 1'b0; lock0 = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1 checkOutput("rstmid_rvalid0", 32'(rvalid0), 32'h0);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 32'h10, 32'h0, 1, 0, 0, 32'h20, 32'h0);
    #2 checkOutput("rstmid_next_gnt0", 32'(gnt0), 32'h1);
    applyStimulus(1, 0, 0, 32'h10, 32'h0, 1, 0, 0, 32'h20, 32'h0);
    #2 checkOutput("rstmid_after_gnt1", 32'(gnt1), 32'h1);
    applyIdle();

`ifdef DMEM_ARB_STATS_EN
    // 70000 grants to R0 wrap the 16-bit counter to 4464.
    doReset();
    applyStimulus(1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    repeat (70000) @(posedge clk);
    #1 req0 = 1'b0;
    #2 checkOutput("stats_gcnt0", 32'(gcnt0), 32'd4464);
    checkOutput("stats_gcnt1", 32'(gcnt1), 32'd0);
`else
    checkOutput("nostats_gcnt0", 32'(gcnt0), 32'd0);
    checkOutput("nostats_gcnt1", 32'(gcnt1), 32'd0);
`endif

    applyIdle();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (1024 x 32, word-addressed by byte address bits [11:2], synchronous write) between two requesters.
- Requester 0 is the pipeline MEM stage; requester 1 is the loader/DMA engine used to preload and dump memory.
- Round-robin arbitration with optional short-term locking and a starvation limit.
- Sits between the requesters and the memory instance, in place of the direct MEM-stage connection.

Parameters:
- ADDR_W, 10: word-address width driven to memory (uses byte address bits [ADDR_W+1:2]).
- DATA_W, 32: data width.
- MAX_BURST, 4: maximum consecutive grants to one requester while the other is requesting (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  access request, requester 0 / 1.
- lock0 / lock1  in  1  ask to keep ownership for the next cycle; only meaningful with reqN.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  32  byte address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  combinational; access accepted this cycle.
- err0 / err1  out  1  combinational with gnt; misaligned address (addr[1:0] != 0).
- rvalid0 / rvalid1  out  1  registered; read data valid this cycle.
- rdata  out  DATA_W  shared read data, qualified by rvalidN.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data; valid the cycle after the address is presented.
- gcnt0 / gcnt1  out  16  grant counters (see Optional Feature).

Behaviour:
- Arbitration: combinational, at most one grant per cycle. A request is granted in the same cycle it is asserted if it wins.
- Single requester active: that requester always wins.
- Both requesting: the locked owner wins if a lock is held. Otherwise the requester other than last_owner wins (round-robin).
- State (all cleared by reset):
  - last_owner: 1 bit, reset 1, so requester 0 wins the first contention.
  - lock_owner: 2 bits (NONE/R0/R1), reset NONE.
  - burst_cnt: 4 bits, reset 0.
  - rd_pend0 / rd_pend1: 1 bit each, reset 0.
- Lock FSM:
  - NONE -> Rn when gntN & lockN.
  - Rn -> NONE when lockN = 0 or reqN = 0 in a cycle.
  - Rn -> NONE (forced) when burst_cnt reaches MAX_BURST while the other requester is requesting. The other requester then wins the next contention; a forced release is never denied.
- burst_cnt:
  - Increments on each consecutive grant to the same owner while the other requester is requesting.
  - Resets to 1 on an owner change.
  - Resets to 0 when the other requester is idle. Saturates at MAX_BURST.
- Memory drive:
  - On a grant: mem_addr = addrN[ADDR_W+1:2], mem_din = wdataN, mem_we = weN & ~errN.
  - With no grant: mem_we = 0, and mem_addr / mem_din hold the requester-0 values.
- Misaligned access: granted (gnt and err both 1). Write is suppressed. A read still returns data from the truncated word address.
- Read latency: rvalidN = 1 exactly one cycle after a read grant (registered rd_pendN); rdata = mem_dout combinationally. Back-to-back reads give one rvalid per cycle.
- Write followed by a read to the same address in the next cycle returns the new data (memory write-first at the clock edge).
- Outputs after reset: gnt/err are 0 if no request is present; rvalid0 = rvalid1 = 0; mem_we = 0; gcnt = 0.
- Reset mid-operation: a pending read is dropped (no rvalid) and any lock is released.
- Requesters must hold req/we/addr/wdata stable until the cycle in which gnt is seen.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: gcnt0 / gcnt1 count grants per requester, 16-bit, wrapping 0xFFFF -> 0. Cleared by reset.
- Undefined: gcnt0 / gcnt1 are tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package/header holds:
  - lock-owner encodings: LOCK_NONE = 2'b00, LOCK_R0 = 2'b01, LOCK_R1 = 2'b10;
  - MEM_WORDS = 1024;
  - the byte-to-word address slicing constants.
- One sub-module is natural: rr_arb2, a 2-way round-robin picker with lock/burst state. It takes req[1:0], lock[1:0] and MAX_BURST, and outputs gnt[1:0].
- Datapath muxing and rvalid registers stay in the top module.

Test Plan:
- Solo traffic: req0 writes 0xDEADBEEF to 0x10, then reads 0x10 -> gnt0 = 1 in both cycles; rvalid0 = 1 the next cycle with rdata = 0xDEADBEEF; gnt1 stays 0.
- Contention after reset: req0 = req1 = 1 (reads) for 4 cycles -> grants R0, R1, R0, R1; each rvalid follows its own grant by one cycle.
- Lock/starvation: MAX_BURST = 4, lock1 = 1 and req1 = 1 continuously, req0 = 1 -> gnt1 for 4 cycles, then gnt0 for 1 cycle, then gnt1 resumes.
- Misaligned write: req1, we1 = 1, addr1 = 0x22, wdata1 = 0x1 -> gnt1 = err1 = 1, mem_we = 0; a later read of 0x20 returns the old value.
- Reset mid-read: read granted to R0 at cycle n, reset asserted before edge n+1 -> rvalid0 = 0 at n+1, lock_owner = NONE, and the next contention is won by R0.
- Stats (DMEM_ARB_STATS_EN): 70000 grants to R0 -> gcnt0 = 70000 mod 65536 = 4464, gcnt1 = 0. Without the macro, both read 0.
